// File: rtl/zeroheti_obi_demux_pkg.sv
// Shared types for the core data-bus demux: subordinate indices, address rules
// and the region table with its conversion to an indexable rule array.
package zeroheti_obi_demux_pkg;

    typedef enum logic [2:0] {DBG, IMEM, DMEM, HETIC, UART, MTIMER, EXT} slv_idx_e;

    localparam int unsigned NumSlv = 7;
    localparam int unsigned IdxW   = 3;
    localparam logic [IdxW-1:0] ERR_IDX = IdxW'(NumSlv);

    // Half-open range: base <= addr < last
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } addr_rule_t;

    typedef struct packed {
        addr_rule_t dbg;
        addr_rule_t imem;
        addr_rule_t dmem;
        addr_rule_t hetic;
        addr_rule_t uart;
        addr_rule_t mtimer;
        addr_rule_t ext;
    } addr_map_t;

    typedef addr_rule_t [NumSlv-1:0] rule_array_t;

    localparam addr_map_t DefaultAddrMap = '{
        dbg:    '{base: 32'h0000_0000, last: 32'h0000_1000},
        imem:   '{base: 32'h0000_5000, last: 32'h0000_A000},
        dmem:   '{base: 32'h0000_A000, last: 32'h0001_3000},
        hetic:  '{base: 32'h0000_1000, last: 32'h0000_2000},
        uart:   '{base: 32'h0000_2000, last: 32'h0000_2100},
        mtimer: '{base: 32'h0000_2100, last: 32'h0000_2114},
        ext:    '{base: 32'h0002_0000, last: 32'hFFFF_FFFF}
    };

    function automatic rule_array_t addr_map_to_array(input addr_map_t map);
        rule_array_t rules;
        rules[DBG]    = map.dbg;
        rules[IMEM]   = map.imem;
        rules[DMEM]   = map.dmem;
        rules[HETIC]  = map.hetic;
        rules[UART]   = map.uart;
        rules[MTIMER] = map.mtimer;
        rules[EXT]    = map.ext;
        return rules;
    endfunction

endpackage

// File: rtl/zeroheti_obi_demux_if.sv
// Bundles the manager-side OBI port and the per-region subordinate ports.
// The demux takes the slave view; the core/peripheral environment the master view.
interface zeroheti_obi_demux_if;
    import zeroheti_obi_demux_pkg::*;

    logic                     mgr_req;
    logic                     mgr_gnt;
    logic [31:0]              mgr_addr;
    logic                     mgr_we;
    logic [3:0]               mgr_be;
    logic [31:0]              mgr_wdata;
    logic                     mgr_rvalid;
    logic [31:0]              mgr_rdata;
    logic                     mgr_err;

    logic [NumSlv-1:0]        sub_req;
    logic [NumSlv-1:0]        sub_gnt;
    logic [31:0]              sub_addr;
    logic                     sub_we;
    logic [3:0]               sub_be;
    logic [31:0]              sub_wdata;
    logic [NumSlv-1:0]        sub_rvalid;
    logic [NumSlv-1:0][31:0]  sub_rdata;
    logic [NumSlv-1:0]        sub_err;

    modport slave (
        input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
        input  sub_gnt, sub_rvalid, sub_rdata, sub_err,
        output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        output sub_req, sub_addr, sub_we, sub_be, sub_wdata
    );

    modport master (
        output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
        output sub_gnt, sub_rvalid, sub_rdata, sub_err,
        input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
        input  sub_req, sub_addr, sub_we, sub_be, sub_wdata
    );

endinterface

// File: rtl/zeroheti_obi_demux_addr_decode.sv
// Combinational address decoder: returns the first rule (lowest index) whose
// half-open range contains the address.
module zeroheti_obi_demux_addr_decode
    import zeroheti_obi_demux_pkg::*;
(
    input  logic [31:0]     i_addr,
    input  rule_array_t     i_rules,
    output logic            o_hit,
    output logic [IdxW-1:0] o_idx
);

    // Scanning downwards lets the lowest matching index win.
    always_comb begin
        o_hit = 1'b0;
        o_idx = ERR_IDX;
        for (int i = NumSlv - 1; i >= 0; i--) begin
            if (i_addr >= i_rules[i].base && i_addr < i_rules[i].last) begin
                o_hit = 1'b1;
                o_idx = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/zeroheti_obi_demux.sv
// Routes the core's OBI data port to the mapped regions, keeps responses in
// order by only switching target once the old one has drained.
module zeroheti_obi_demux
    import zeroheti_obi_demux_pkg::*;
#(
    parameter addr_map_t   AddrMap  = DefaultAddrMap,
    parameter int unsigned MaxTrans = 4,
    parameter logic [31:0] ErrRdata = 32'hBADC_AB1E
) (
    input logic                 clk_i,
    input logic                 rst_i,
    zeroheti_obi_demux_if.slave bus
);

    localparam int unsigned     CntW   = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);
    localparam rule_array_t     Rules  = addr_map_to_array(AddrMap);

    logic [CntW-1:0]   r_cnt;
    logic [IdxW-1:0]   r_sel;
    logic              r_errPend;
    logic [1:0]        r_guard;

    logic              w_hit;
    logic [IdxW-1:0]   w_decIdx;
    logic [IdxW-1:0]   w_dec;
    logic [NumSlv-1:0] w_decOh;
    logic [NumSlv-1:0] w_selOh;
    logic              w_fwd;
    logic              w_gnt;
    logic              w_acc;
    logic              w_rvalid;
    logic              w_err;
    logic [31:0]       w_slvRdata;
    logic [31:0]       w_rdata;

    zeroheti_obi_demux_addr_decode u_decode (
        .i_addr  (bus.mgr_addr),
        .i_rules (Rules),
        .o_hit   (w_hit),
        .o_idx   (w_decIdx)
    );

    assign w_dec = w_hit ? w_decIdx : ERR_IDX;

    for (genvar g = 0; g < NumSlv; g++) begin : g_slv
        assign w_decOh[g]     = (w_dec == IdxW'(g));
        assign w_selOh[g]     = (r_sel == IdxW'(g));
        assign bus.sub_req[g] = !rst_i && w_fwd && bus.mgr_req && w_decOh[g];
    end

    assign bus.sub_addr  = bus.mgr_addr;
    assign bus.sub_we    = bus.mgr_we;
    assign bus.sub_be    = bus.mgr_be;
    assign bus.sub_wdata = bus.mgr_wdata;

    always_comb begin
        w_slvRdata = '0;
        for (int i = 0; i < NumSlv; i++) begin
            if (w_selOh[i]) begin
                w_slvRdata = w_slvRdata | bus.sub_rdata[i];
            end
        end
    end

    // Responses are only honoured while something is outstanding, so stale
    // subordinate responses after a reset never reach the manager.
    assign w_rvalid = (r_cnt != '0) &&
                      ((r_sel == ERR_IDX) ? r_errPend : |(bus.sub_rvalid & w_selOh));
    assign w_err    = (r_sel == ERR_IDX) ? 1'b1 : |(bus.sub_err & w_selOh);
    assign w_rdata  = (r_sel == ERR_IDX) ? ErrRdata : w_slvRdata;

    // A draining response frees a slot and, if it is the last one, the target.
    assign w_fwd = (r_cnt == '0 || w_dec == r_sel || (r_cnt == CntW'(1) && w_rvalid)) &&
                   (r_cnt < CntMax || w_rvalid);
    assign w_gnt = w_fwd && ((w_dec == ERR_IDX) || |(bus.sub_gnt & w_decOh));
    assign w_acc = bus.mgr_req && w_gnt;

    assign bus.mgr_gnt    = !rst_i && w_gnt;
    assign bus.mgr_rvalid = !rst_i && w_rvalid;
    assign bus.mgr_rdata  = (!rst_i && w_rvalid) ? w_rdata : 32'h0;
    assign bus.mgr_err    = !rst_i && w_rvalid && w_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_sel     <= ERR_IDX;
            r_errPend <= 1'b0;
            r_guard   <= 2'd2;
        end else begin
            if (w_acc) begin
                r_sel <= w_dec;
            end
            r_errPend <= w_acc && (w_dec == ERR_IDX);
            if (w_acc && !w_rvalid) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_acc && w_rvalid) begin
                r_cnt <= r_cnt - CntW'(1);
            end
            if (r_guard != 2'd0) begin
                r_guard <= r_guard - 2'd1;
            end
        end
    end

    a_noRspWhenIdle: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_cnt == '0 && r_guard == 2'd0) |-> !(|bus.sub_rvalid));

    a_reqHeldUntilGnt: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.mgr_req && !bus.mgr_gnt) |=> bus.mgr_req);

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// Directed bench for the core data-bus demux: routing, stalls, error responder,
// region boundaries and reset with transactions in flight.
module tb_zeroheti_obi_demux;
    import zeroheti_obi_demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   passCount  = 0;
    int   checkCount = 0;
    logic [31:0] bAddr [6];
    logic [6:0]  bSel  [6];

    always #5 clk = ~clk;

    zeroheti_obi_demux_if bus ();

    zeroheti_obi_demux dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic we,
                                 input logic [6:0] gnt, input logic [6:0] rvalid);
        bus.mgr_req    = req;
        bus.mgr_addr   = addr;
        bus.mgr_we     = we;
        bus.mgr_be     = 4'hF;
        bus.mgr_wdata  = 32'h5A5A_0000 ^ addr;
        bus.sub_gnt    = gnt;
        bus.sub_rvalid = rvalid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NumSlv; i++) begin
            bus.sub_rdata[i] = 32'hC0DE_0000 | 32'(i);
        end
        bus.sub_err = '0;
        bAddr = '{32'h0000_0FFF, 32'h0000_1000, 32'h0001_2FFF,
                  32'h0001_3000, 32'h0002_0000, 32'hFFFF_FFFF};
        bSel  = '{7'b0000001, 7'b0001000, 7'b0000100, 7'b0000000, 7'b1000000, 7'b0000000};

        // Reset holds every manager-facing output low even with busy inputs
        rst = 1'b1;
        applyStimulus(1'b1, 32'h5000, 1'b0, 7'h7F, 7'h7F);
        #1;
        checkOutput("rst_gnt",    32'(bus.mgr_gnt), 32'd0);
        checkOutput("rst_rvalid", 32'(bus.mgr_rvalid), 32'd0);
        checkOutput("rst_rdata",  bus.mgr_rdata, 32'd0);
        checkOutput("rst_err",    32'(bus.mgr_err), 32'd0);
        checkOutput("rst_subreq", 32'(bus.sub_req), 32'd0);
        checkOutput("rst_cnt",    32'(dut.r_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00);
        #1;
        checkOutput("rst_sel", 32'(dut.r_sel), 32'd7);

        // Read imem
        nextCycle(); applyStimulus(1'b1, 32'h5000, 1'b0, 7'b0000010, 7'h00); #1;
        checkOutput("imem_subreq", 32'(bus.sub_req), 32'h02);
        checkOutput("imem_gnt",    32'(bus.mgr_gnt), 32'd1);
        checkOutput("imem_addr",   bus.sub_addr, 32'h5000);
        nextCycle(); applyStimulus(1'b0, 32'h5000, 1'b0, 7'h00, 7'b0000010); #1;
        checkOutput("imem_cnt1",   32'(dut.r_cnt), 32'd1);
        checkOutput("imem_rvalid", 32'(bus.mgr_rvalid), 32'd1);
        checkOutput("imem_rdata",  bus.mgr_rdata, 32'hC0DE_0001);
        checkOutput("imem_err",    32'(bus.mgr_err), 32'd0);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("imem_cnt0",   32'(dut.r_cnt), 32'd0);
        checkOutput("imem_idle",   32'(bus.mgr_rvalid), 32'd0);

        // Write mtimer, then uart read must wait for the mtimer response
        nextCycle(); applyStimulus(1'b1, 32'h2100, 1'b1, 7'b0100000, 7'h00); #1;
        checkOutput("mt_subreq", 32'(bus.sub_req), 32'h20);
        checkOutput("mt_gnt",    32'(bus.mgr_gnt), 32'd1);
        checkOutput("mt_we",     32'(bus.sub_we), 32'd1);
        nextCycle(); applyStimulus(1'b1, 32'h2000, 1'b0, 7'b0010000, 7'h00); #1;
        checkOutput("uart_stall_req", 32'(bus.sub_req), 32'h00);
        checkOutput("uart_stall_gnt", 32'(bus.mgr_gnt), 32'd0);
        nextCycle(); applyStimulus(1'b1, 32'h2000, 1'b0, 7'b0010000, 7'b0100000); #1;
        checkOutput("mt_rvalid",   32'(bus.mgr_rvalid), 32'd1);
        checkOutput("mt_err",      32'(bus.mgr_err), 32'd0);
        checkOutput("uart_subreq", 32'(bus.sub_req), 32'h10);
        checkOutput("uart_gnt",    32'(bus.mgr_gnt), 32'd1);
        nextCycle(); applyStimulus(1'b0, 32'h2000, 1'b0, 7'h00, 7'b0010000); #1;
        checkOutput("uart_cnt",   32'(dut.r_cnt), 32'd1);
        checkOutput("uart_rdata", bus.mgr_rdata, 32'hC0DE_0004);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("uart_cnt0",  32'(dut.r_cnt), 32'd0);

        // Unmapped hole goes to the error responder
        nextCycle(); applyStimulus(1'b1, 32'h3000, 1'b0, 7'h7F, 7'h00); #1;
        checkOutput("hole_subreq", 32'(bus.sub_req), 32'h00);
        checkOutput("hole_gnt",    32'(bus.mgr_gnt), 32'd1);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("hole_rvalid", 32'(bus.mgr_rvalid), 32'd1);
        checkOutput("hole_err",    32'(bus.mgr_err), 32'd1);
        checkOutput("hole_rdata",  bus.mgr_rdata, 32'hBADC_AB1E);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("hole_idle",   32'(bus.mgr_rvalid), 32'd0);
        checkOutput("hole_cnt0",   32'(dut.r_cnt), 32'd0);

        // Fill the outstanding window with dmem reads
        for (int k = 0; k < 4; k++) begin
            nextCycle(); applyStimulus(1'b1, 32'hA000 + 32'(k * 4), 1'b0, 7'b0000100, 7'h00); #1;
            checkOutput("dmem_gnt", 32'(bus.mgr_gnt), 32'd1);
        end
        nextCycle(); applyStimulus(1'b1, 32'hA010, 1'b0, 7'b0000100, 7'h00); #1;
        checkOutput("full_cnt",    32'(dut.r_cnt), 32'd4);
        checkOutput("full_gnt",    32'(bus.mgr_gnt), 32'd0);
        checkOutput("full_subreq", 32'(bus.sub_req), 32'h00);
        nextCycle(); applyStimulus(1'b1, 32'hA010, 1'b0, 7'b0000100, 7'b0000100); #1;
        checkOutput("drain_rvalid", 32'(bus.mgr_rvalid), 32'd1);
        checkOutput("drain_gnt",    32'(bus.mgr_gnt), 32'd1);
        checkOutput("drain_subreq", 32'(bus.sub_req), 32'h04);
        for (int k = 0; k < 4; k++) begin
            nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'b0000100); #1;
            checkOutput("drain_cnt", 32'(dut.r_cnt), 32'(4 - k));
        end
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("dmem_cnt0", 32'(dut.r_cnt), 32'd0);

        // Region boundaries, each completed with a response
        for (int k = 0; k < 6; k++) begin
            nextCycle(); applyStimulus(1'b1, bAddr[k], 1'b0, 7'h7F, 7'h00); #1;
            checkOutput($sformatf("bnd_subreq_%h", bAddr[k]), 32'(bus.sub_req), 32'(bSel[k]));
            checkOutput($sformatf("bnd_gnt_%h", bAddr[k]), 32'(bus.mgr_gnt), 32'd1);
            nextCycle(); applyStimulus(1'b0, bAddr[k], 1'b0, 7'h00, bSel[k]); #1;
            checkOutput($sformatf("bnd_rvalid_%h", bAddr[k]), 32'(bus.mgr_rvalid), 32'd1);
            checkOutput($sformatf("bnd_err_%h", bAddr[k]), 32'(bus.mgr_err), 32'(bSel[k] == 7'd0));
        end

        // Reset with three dmem reads outstanding
        for (int k = 0; k < 3; k++) begin
            nextCycle(); applyStimulus(1'b1, 32'hA000 + 32'(k * 4), 1'b0, 7'b0000100, 7'h00); #1;
            checkOutput("pre_gnt", 32'(bus.mgr_gnt), 32'd1);
        end
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'b0000100); #1;
        checkOutput("pre_rst_cnt",    32'(dut.r_cnt), 32'd3);
        checkOutput("pre_rst_rvalid", 32'(bus.mgr_rvalid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("async_rvalid", 32'(bus.mgr_rvalid), 32'd0);
        checkOutput("async_rdata",  bus.mgr_rdata, 32'd0);
        checkOutput("async_cnt",    32'(dut.r_cnt), 32'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'b0000100);
        #1;
        checkOutput("stale_rvalid", 32'(bus.mgr_rvalid), 32'd0);
        nextCycle(); applyStimulus(1'b1, 32'hA000, 1'b0, 7'b0000100, 7'h00); #1;
        checkOutput("fresh_gnt",    32'(bus.mgr_gnt), 32'd1);
        checkOutput("fresh_subreq", 32'(bus.sub_req), 32'h04);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'b0000100); #1;
        checkOutput("fresh_rvalid", 32'(bus.mgr_rvalid), 32'd1);
        checkOutput("fresh_rdata",  bus.mgr_rdata, 32'hC0DE_0002);
        checkOutput("fresh_err",    32'(bus.mgr_err), 32'd0);
        nextCycle(); applyStimulus(1'b0, 32'h0, 1'b0, 7'h00, 7'h00); #1;
        checkOutput("fresh_cnt0",   32'(dut.r_cnt), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
